// File: rtl/nzcv_cond_eval.sv
// NZCV flags register plus ARM condition evaluator; 1-cycle result in a one-entry valid/ready register, stalls when full and not drained.
// Optional NZCV_FLAG_BYPASS_EN: an evaluation accepted alongside a flag write sees the incoming flags.
module nzcv_cond_eval #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flag_we,
  input  logic             n_in,
  input  logic             z_in,
  input  logic             c_in,
  input  logic             v_in,
  input  logic             cond_valid,
  input  logic [3:0]       cond,
  output logic             cond_ready,
  output logic             pass_valid,
  output logic             pass,
  input  logic             pass_ready,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v,
  output logic [CNT_W-1:0] pass_cnt
);

  logic accept;
  logic consume;
  logic eval_n, eval_z, eval_c, eval_v;
  logic eval_pass;

  function automatic logic cond_table(input logic [3:0] cc, input logic fn, input logic fz,
                                      input logic fc, input logic fv);
    logic res;
    res = 1'b1;
    case (cc)
      4'd0:  res = fz;
      4'd1:  res = ~fz;
      4'd2:  res = fc;
      4'd3:  res = ~fc;
      4'd4:  res = fn;
      4'd5:  res = ~fn;
      4'd6:  res = fv;
      4'd7:  res = ~fv;
      4'd8:  res = fc & ~fz;
      4'd9:  res = ~fc | fz;
      4'd10: res = (fn == fv);
      4'd11: res = (fn != fv);
      4'd12: res = ~fz & (fn == fv);
      4'd13: res = fz | (fn != fv);
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  assign cond_ready = ~pass_valid | pass_ready;
  assign accept     = cond_valid & cond_ready;
  assign consume    = pass_valid & pass_ready;

`ifdef NZCV_FLAG_BYPASS_EN
  assign eval_n = flag_we ? n_in : n;
  assign eval_z = flag_we ? z_in : z;
  assign eval_c = flag_we ? c_in : c;
  assign eval_v = flag_we ? v_in : v;
`else
  assign eval_n = n;
  assign eval_z = z;
  assign eval_c = c;
  assign eval_v = v;
`endif

  // Masked with accept so an idle or X cond never reaches the result register.
  assign eval_pass = accept & cond_table(cond, eval_n, eval_z, eval_c, eval_v);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n <= 1'b0;
      z <= 1'b0;
      c <= 1'b0;
      v <= 1'b0;
    end else if (flag_we) begin
      n <= n_in;
      z <= z_in;
      c <= c_in;
      v <= v_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_valid <= 1'b0;
      pass       <= 1'b0;
    end else if (accept) begin
      pass_valid <= 1'b1;
      pass       <= eval_pass;
    end else if (consume) begin
      pass_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt <= '0;
    end else if (consume && pass && (pass_cnt != {CNT_W{1'b1}})) begin
      pass_cnt <= pass_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
